mdio_master_arb: RTL and testbench
==================================

# mdio_master_arb

Shared MDIO management master for the Ethernet subsystem. It arbitrates round-robin between several on-chip clients: PHY bring-up logic, link monitor and the host register bridge. It serialises one Clause-22 read or write frame at a time onto a single MDC/MDIO pair, generating MDC from the system clock. The MDIO pad tristate is built at the top level from `mdio_o`/`mdio_oe`/`mdio_i`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesting clients (1–8).
- `CLK_DIV`, 4: MDC half-period in `clk` cycles (≥2); MDC period = 2·CLK_DIV.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-client request; held high until `gnt`.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_phy`  in  5·NUM_REQ  PHY address per client, client i at [5i+4:5i].
- `req_reg`  in  5·NUM_REQ  register address per client.
- `req_wdata`  in  16·NUM_REQ  write data per client.
- `gnt`  out  NUM_REQ  one-cycle one-hot pulse; request fields latched this cycle.
- `done`  out  NUM_REQ  one-cycle one-hot pulse at frame completion.
- `rdata`  out  16  read data, valid in the `done` cycle of a read; holds until the next read completes.
- `busy`  out  1  high from `gnt` cycle through `done` cycle.
- `mdc`  out  1  management clock.
- `mdio_o`  out  1  serial data out.
- `mdio_oe`  out  1  output enable for the MDIO pad.
- `mdio_i`  in  1  serial data in from the pad.

## Operation
- Reset: `gnt`=0, `done`=0, `rdata`=0, `busy`=0, `mdc`=0, `mdio_o`=1, `mdio_oe`=0, RR pointer=0, state IDLE.
- States: IDLE → PRE → HDR → TA → DATA → DONE → IDLE.
- IDLE: with any `req` high, grant the first requester at or after the RR pointer (wrapping). Pulse `gnt`, latch op/phy/reg/wdata, set pointer to winner+1 mod NUM_REQ, go to PRE.
- PRE: 32 bits of 1, driven.
- HDR: 14 bits, MSB first, driven. Bits are start `01`, op (`01` write, `10` read), phy[4:0], reg[4:0].
- TA, write: drive `10`. TA, read: `mdio_oe`=0 for both bits.
- DATA, write: drive wdata[15:0], MSB first. DATA, read: `mdio_oe`=0; shift `mdio_i` in MSB first.
- DONE: pulse `done[winner]` for one cycle; on a read, update `rdata`. Return to IDLE.
- Requests are evaluated only in IDLE. Requests raised mid-frame wait for the next IDLE.
- A `req` still high after its `gnt` counts as a new request.
- With simultaneous requests, service order is pointer order, so no client is served twice while another waits.
- Reset mid-frame: the next cycle gives `mdc`=0, `mdio_oe`=0, no `done`, and the pointer returns to 0.

## Timing
- Bit period = 2·CLK_DIV cycles. `mdc` is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
- `mdio_o`/`mdio_oe` update on the cycle `mdc` falls, which is the bit start. This gives CLK_DIV cycles of setup and hold to the rising edge.
- Read bits are sampled from `mdio_i` on the cycle `mdc` rises.
- In IDLE, `mdc` is held at 0 and `mdio_oe` at 0.
- With `gnt` at cycle T, bit 0 starts at T+1.
- The frame is 64 bits (preamble compiled in) or 32 bits (preamble compiled out).
- `done` pulses at T+1+64·2·CLK_DIV; with the defaults, T+513.
- The earliest next `gnt` is the cycle after `done`. This gives at least one idle cycle between frames.

## Configuration
- `MDIO_PREAMBLE_EN` defined: the 32-bit all-ones preamble precedes every frame.
- `MDIO_PREAMBLE_EN` undefined: PRE is skipped and the frame starts directly with `01`. This is preamble suppression, for PHYs that support it.
- Everything else is unchanged.

## Test plan
- Single write: client 0, phy=0, reg=0x18, wdata=0x2000. Captured MDIO bits are 32 ones, then `01 01 00000 11000 10 0010000000000000`. `done[0]` at T+513. `mdio_oe` is high throughout.
- Single read: client 1, phy=3, reg=0x02; the PHY model returns 0x0141. During TA/DATA `mdio_oe`=0. `rdata`=0x0141 with `done[1]`.
- Contention: `req`=2'b11 from reset. Order is gnt[0], then gnt[1] on the cycle after done[0]. If req[0] is held throughout, order is 0,1,0,1.
- Reset mid-frame: assert `rst` for 1 cycle at bit 40. Next cycle gives `mdc`=0, `mdio_oe`=0, `busy`=0, and no `done`. A new request then completes normally.
- Preamble compiled out: the write from scenario 1 starts with `01` at T+1. `done` at T+257.
- CLK_DIV=2: `mdc` period is 4 cycles. `mdio_o` changes only on falling-edge cycles. The read sample is taken on rising-edge cycles.

Source files
------------

// File: rtl/mdio_master_arb_if.sv
// mdio_master_arb_if: client request/grant bus of the shared MDIO master
interface mdio_master_arb_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_write;
  logic [5*NUM_REQ-1:0] req_phy;
  logic [5*NUM_REQ-1:0] req_reg;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [15:0] rdata;
  logic busy;
  modport slave (
    input  req, req_write, req_phy, req_reg, req_wdata,
    output gnt, done, rdata, busy
  );
  modport master (
    output req, req_write, req_phy, req_reg, req_wdata,
    input  gnt, done, rdata, busy
  );
endinterface

// File: rtl/mdio_master_arb.sv
// mdio_master_arb: round-robin arbitrated Clause-22 MDIO master; define MDIO_PREAMBLE_EN for the 32-bit preamble
module mdio_master_arb #(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  mdio_master_arb_if.slave bus,
  output logic mdc,
  output logic mdio_o,
  output logic mdio_oe,
  input  logic mdio_i
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;
`ifdef MDIO_PREAMBLE_EN
  localparam state_t FIRST = PRE;
`else
  localparam state_t FIRST = HDR;
`endif
  state_t state_q, state_d, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] bidx_q, bidx_d, blast;
  logic [31:0] sr_q, sr_d;
  logic [15:0] rsr_q, rsr_d, rdata_q, rdata_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic wr_q, wr_d, mdc_d, mdio_o_d, mdio_oe_d, found, load;
  assign bus.gnt = (state_q == IDLE && found) ? NUM_REQ'(1) << pick : '0;
  assign bus.done = state_q == DONE ? NUM_REQ'(1) << win_q : '0;
  assign bus.busy = state_q != IDLE || (|bus.gnt);
  assign bus.rdata = rdata_q;
  assign blast = state_q == PRE ? 5'd31 : state_q == HDR ? 5'd13 : state_q == TA ? 5'd1 : 5'd15;
  assign nxt = state_q == PRE ? HDR : state_q == HDR ? TA : state_q == TA ? DATA : DONE;
  always_comb begin
    found = 1'b0;
    pick = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick = PW'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bidx_d = bidx_q;
    sr_d = sr_q;
    rsr_d = rsr_q;
    rdata_d = rdata_q;
    ptr_d = ptr_q;
    win_d = win_q;
    wr_d = wr_q;
    mdc_d = mdc;
    mdio_o_d = mdio_o;
    mdio_oe_d = mdio_oe;
    load = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        win_d = pick;
        ptr_d = pick == PW'(NUM_REQ - 1) ? '0 : pick + 1'b1;
        wr_d = bus.req_write[pick];
        sr_d = {2'b01, bus.req_write[pick] ? 2'b01 : 2'b10, bus.req_phy[5*pick +: 5],
                bus.req_reg[5*pick +: 5], 2'b10, bus.req_wdata[16*pick +: 16]};
        state_d = FIRST;
        cnt_d = '0;
        bidx_d = '0;
        load = 1'b1;
      end
      DONE: state_d = IDLE;
      default: begin
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        mdc_d = cnt_d > HALF;
        // read data is captured on the cycle mdc rises, mid-bit
        if (state_q == DATA && !wr_q && cnt_q == HALF) rsr_d = {rsr_q[14:0], mdio_i};
        if (cnt_q == LAST) begin
          state_d = bidx_q == blast ? nxt : state_q;
          bidx_d = bidx_q == blast ? '0 : bidx_q + 1'b1;
          load = state_d != DONE;
          if (state_d == DONE) begin
            mdio_o_d = 1'b1;
            mdio_oe_d = 1'b0;
            rdata_d = wr_q ? rdata_q : rsr_q;
          end
        end
      end
    endcase
    // every bit starts with mdc low and new pad data
    if (load) begin
      mdio_o_d = (state_d == PRE) || sr_d[31];
      mdio_oe_d = state_d == PRE || state_d == HDR || wr_d;
      sr_d = state_d == PRE ? sr_d : sr_d << 1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bidx_q <= '0;
      sr_q <= '0;
      rsr_q <= '0;
      rdata_q <= '0;
      ptr_q <= '0;
      win_q <= '0;
      wr_q <= 1'b0;
      mdc <= 1'b0;
      mdio_o <= 1'b1;
      mdio_oe <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bidx_q <= bidx_d;
      sr_q <= sr_d;
      rsr_q <= rsr_d;
      rdata_q <= rdata_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      wr_q <= wr_d;
      mdc <= mdc_d;
      mdio_o <= mdio_o_d;
      mdio_oe <= mdio_oe_d;
    end
  end
endmodule

// File: tb/tb_mdio_master_arb.sv
// tb_mdio_master_arb: directed bench for mdio_master_arb, CLK_DIV=4 and CLK_DIV=2 instances
module tb_mdio_master_arb;
  localparam int N = 2;
`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
  localparam logic [63:0] WR_EXP = {32'hFFFF_FFFF, 32'h5062_2000};
  localparam logic [63:0] RD_HDR = {18'd0, 32'hFFFF_FFFF, 14'h1862};
`else
  localparam int PRE = 0;
  localparam logic [63:0] WR_EXP = {32'd0, 32'h5062_2000};
  localparam logic [63:0] RD_HDR = {50'd0, 14'h1862};
`endif
  localparam int FB = PRE + 32;
  localparam int RB = PRE > 0 ? 40 : 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mdio_master_arb_if #(.NUM_REQ(N)) b0 ();
  mdio_master_arb_if #(.NUM_REQ(N)) b1 ();
  logic [1:0] mdc, mdio_o, mdio_oe, mdio_i;
  mdio_master_arb #(.NUM_REQ(N), .CLK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .bus(b0), .mdc(mdc[0]), .mdio_o(mdio_o[0]), .mdio_oe(mdio_oe[0]), .mdio_i(mdio_i[0])
  );
  mdio_master_arb #(.NUM_REQ(N), .CLK_DIV(2)) u1 (
    .clk(clk), .rst(rst), .bus(b1), .mdc(mdc[1]), .mdio_o(mdio_o[1]), .mdio_oe(mdio_oe[1]), .mdio_i(mdio_i[1])
  );
  int n_cmp = 0, n_bad = 0, cyc = 0, ng = 0, nd = 0;
  int ncap [2] = '{0, 0};
  int ndone [2] = '{0, 0};
  int gcount [2] = '{0, 0};
  int tg [2] = '{0, 0};
  int td [2] = '{0, 0};
  int last_rise [2] = '{-1, -1};
  int hi [2] = '{0, 0};
  int perr [2] = '{0, 0};
  int viol [2] = '{0, 0};
  logic cap [2][64];
  logic capoe [2][64];
  logic [1:0] gv [2];
  logic [1:0] dvv [2];
  logic [1:0] dv [2];
  logic [15:0] dr [2];
  logic [15:0] rdo [2];
  logic [1:0] gl_v [64];
  logic [1:0] dl_v [64];
  int gl_t [64];
  int dl_t [64];
  logic mdc_p [2] = '{1'b0, 1'b0};
  logic o_p [2] = '{1'b1, 1'b1};
  logic oe_p [2] = '{1'b0, 1'b0};
  logic gp [2] = '{1'b0, 1'b0};
  logic rst_p = 1'b1;
  logic [15:0] rdv0 = 16'h0141;
  logic [15:0] rdv1 = 16'hBEEF;
  assign gv[0] = b0.gnt;
  assign gv[1] = b1.gnt;
  assign dvv[0] = b0.done;
  assign dvv[1] = b1.done;
  assign rdo[0] = b0.rdata;
  assign rdo[1] = b1.rdata;
  // PHY model: drives read data for the 16 data bits, counting mdc rises since the grant
  assign mdio_i[0] = (ncap[0] >= PRE + 16 && ncap[0] < PRE + 32) ? rdv0[PRE + 31 - ncap[0]] : 1'b1;
  assign mdio_i[1] = (ncap[1] >= PRE + 16 && ncap[1] < PRE + 32) ? rdv1[PRE + 31 - ncap[1]] : 1'b1;

  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (|gv[j]) begin
        tg[j] = cyc;
        gcount[j]++;
        ncap[j] = 0;
        last_rise[j] = -1;
      end
      if (mdc[j] && !mdc_p[j]) begin
        if (ncap[j] < 64) begin
          cap[j][ncap[j]] = mdio_o[j];
          capoe[j][ncap[j]] = mdio_oe[j];
        end
        ncap[j]++;
        if (last_rise[j] >= 0 && cyc - last_rise[j] != (j == 0 ? 8 : 4) && !rst_p) perr[j]++;
        last_rise[j] = cyc;
        hi[j] = 0;
      end
      if (mdc[j]) hi[j]++;
      if (!mdc[j] && mdc_p[j] && hi[j] != (j == 0 ? 4 : 2) && !rst_p) perr[j]++;
      if (((mdio_o[j] != o_p[j]) || (mdio_oe[j] != oe_p[j])) && !(mdc_p[j] && !mdc[j]) && !gp[j] && !rst && !rst_p)
        viol[j]++;
      if (|dvv[j]) begin
        td[j] = cyc;
        dv[j] = dvv[j];
        dr[j] = rdo[j];
        ndone[j]++;
      end
      mdc_p[j] = mdc[j];
      o_p[j] = mdio_o[j];
      oe_p[j] = mdio_oe[j];
      gp[j] = |gv[j];
    end
    if (|b0.gnt && ng < 64) begin
      gl_v[ng] = b0.gnt;
      gl_t[ng] = cyc;
      ng++;
    end
    if (|b0.done && nd < 64) begin
      dl_v[nd] = b0.done;
      dl_t[nd] = cyc;
      nd++;
    end
    rst_p = rst;
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue0(input int c, input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d);
    int target;
    target = gcount[0] + 1;
    @(posedge clk); #1;
    b0.req_write[c] = w;
    b0.req_phy[5*c +: 5] = p;
    b0.req_reg[5*c +: 5] = r;
    b0.req_wdata[16*c +: 16] = d;
    b0.req[c] = 1'b1;
    for (int k = 0; k < 100 && gcount[0] < target; k++) @(negedge clk);
    chk("gnt_wait", 64'(gcount[0] >= target), 64'd1);
    @(posedge clk); #1;
    b0.req[c] = 1'b0;
  endtask

  task automatic wait_done(input int j, input int target, input string tag);
    for (int k = 0; k < 4000 && ndone[j] < target; k++) @(negedge clk);
    chk(tag, 64'(ndone[j] >= target), 64'd1);
  endtask

  function automatic logic [63:0] bits(input int j, input int from, input int cnt);
    logic [63:0] v = '0;
    for (int k = from; k < from + cnt; k++) v = {v[62:0], cap[j][k]};
    return v;
  endfunction

  function automatic int oe_ones(input int j, input int cnt);
    int s = 0;
    for (int k = 0; k < cnt; k++) s += int'(capoe[j][k]);
    return s;
  endfunction

  initial begin
    int n0, g0;
    b0.req = '0; b0.req_write = '0; b0.req_phy = '0; b0.req_reg = '0; b0.req_wdata = '0;
    b1.req = '0; b1.req_write = '0; b1.req_phy = '0; b1.req_reg = '0; b1.req_wdata = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mdc", 64'(mdc[0]), 64'd0);
    chk("rst_mdio_o", 64'(mdio_o[0]), 64'd1);
    chk("rst_oe", 64'(mdio_oe[0]), 64'd0);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_done", 64'(b0.done), 64'd0);
    chk("rst_rdata", 64'(b0.rdata), 64'd0);
    chk("rst_mdc2", 64'(mdc[1]), 64'd0);

    n0 = ndone[0];
    issue0(0, 1'b1, 5'd0, 5'h18, 16'h2000);
    wait_done(0, n0 + 1, "wr_wait");
    chk("wr_latency", 64'(td[0] - tg[0]), 64'(FB * 8 + 1));
    chk("wr_done", 64'(dv[0]), 64'b01);
    chk("wr_nbits", 64'(ncap[0]), 64'(FB));
    chk("wr_frame", bits(0, 0, FB), WR_EXP);
    chk("wr_oe", 64'(oe_ones(0, FB)), 64'(FB));

    n0 = ndone[0];
    issue0(1, 1'b0, 5'd3, 5'h02, 16'h0);
    wait_done(0, n0 + 1, "rd_wait");
    chk("rd_latency", 64'(td[0] - tg[0]), 64'(FB * 8 + 1));
    chk("rd_done", 64'(dv[0]), 64'b10);
    chk("rd_rdata", 64'(dr[0]), 64'h0141);
    chk("rd_hdr", bits(0, 0, PRE + 14), RD_HDR);
    chk("rd_oe", 64'(oe_ones(0, FB)), 64'(PRE + 14));
    chk("rd_ta_oe", 64'(capoe[0][PRE + 14]), 64'd0);

    n0 = ndone[0];
    issue0(0, 1'b1, 5'h1f, 5'h1f, 16'hFFFF);
    wait_done(0, n0 + 1, "wr2_wait");
    chk("wr2_frame", bits(0, PRE, 32), 64'h5FFE_FFFF);
    chk("wr2_done", 64'(dv[0]), 64'b01);
    @(negedge clk);
    chk("rdata_hold", 64'(b0.rdata), 64'h0141);

    n0 = ndone[0];
    issue0(0, 1'b1, 5'd0, 5'd0, 16'h1234);
    for (int k = 0; k < 2000 && ncap[0] < RB; k++) @(negedge clk);
    chk("mid_reach", 64'(ncap[0] >= RB), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_mdc", 64'(mdc[0]), 64'd0);
    chk("mid_oe", 64'(mdio_oe[0]), 64'd0);
    chk("mid_busy", 64'(b0.busy), 64'd0);
    chk("mid_done", 64'(b0.done), 64'd0);
    repeat (700) @(negedge clk);
    chk("mid_nodone", 64'(ndone[0]), 64'(n0));

    n0 = nd;
    g0 = ng;
    @(posedge clk); #1;
    b0.req_write = 2'b11;
    b0.req = 2'b11;
    for (int k = 0; k < 3000 && ng < g0 + 4; k++) @(negedge clk);
    chk("cont_gnts", 64'(ng >= g0 + 4), 64'd1);
    @(posedge clk); #1 b0.req = 2'b00;
    wait_done(0, ndone[0] + (n0 + 4 - nd), "cont_wait");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_gnt%0d", k), 64'(gl_v[g0 + k]), k % 2 == 0 ? 64'b01 : 64'b10);
      chk($sformatf("cont_done%0d", k), 64'(dl_v[n0 + k]), k % 2 == 0 ? 64'b01 : 64'b10);
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("cont_gap%0d", k), 64'(gl_t[g0 + k + 1] - dl_t[n0 + k]), 64'd1);

    n0 = ndone[1];
    g0 = gcount[1];
    @(posedge clk); #1;
    b1.req_phy[4:0] = 5'd1;
    b1.req_reg[4:0] = 5'd1;
    b1.req[0] = 1'b1;
    for (int k = 0; k < 100 && gcount[1] <= g0; k++) @(negedge clk);
    chk("d2_gnt", 64'(gcount[1] > g0), 64'd1);
    @(posedge clk); #1 b1.req[0] = 1'b0;
    wait_done(1, n0 + 1, "d2_wait");
    chk("d2_latency", 64'(td[1] - tg[1]), 64'(FB * 4 + 1));
    chk("d2_done", 64'(dv[1]), 64'b01);
    chk("d2_rdata", 64'(dr[1]), 64'hBEEF);

    chk("mdc_timing", 64'(perr[0]), 64'd0);
    chk("mdc_timing2", 64'(perr[1]), 64'd0);
    chk("bit_align", 64'(viol[0]), 64'd0);
    chk("bit_align2", 64'(viol[1]), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
